// File: rtl/axil_cordic.sv
// AXI4-Lite slave around an iterative degree-domain CORDIC producing Q1.15 cos/sin.
// Define CORDIC_IRQ_EN to add a registered completion interrupt output (irq).
module axil_cordic #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned CLK_DIV    = 10
) (
  input  logic                  S_AXI_ACLK,
  input  logic                  S_AXI_ARESET,
  input  logic [ADDR_WIDTH-1:0] S_AXI_AWADDR,
  input  logic                  S_AXI_AWVALID,
  output logic                  S_AXI_AWREADY,
  input  logic [31:0]           S_AXI_WDATA,
  input  logic [3:0]            S_AXI_WSTRB,
  input  logic                  S_AXI_WVALID,
  output logic                  S_AXI_WREADY,
  output logic [1:0]            S_AXI_BRESP,
  output logic                  S_AXI_BVALID,
  input  logic                  S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0] S_AXI_ARADDR,
  input  logic                  S_AXI_ARVALID,
  output logic                  S_AXI_ARREADY,
  output logic [31:0]           S_AXI_RDATA,
  output logic [1:0]            S_AXI_RRESP,
  output logic                  S_AXI_RVALID,
  input  logic                  S_AXI_RREADY
`ifdef CORDIC_IRQ_EN
  ,
  output logic                  irq
`endif
);

  localparam int unsigned XW    = 24;
  localparam int unsigned ZW    = 26;
  localparam int unsigned GUARD = 4;
  // Angles are fixed-point degrees with 16 fractional bits; x0 = K * 2^15 * 2^GUARD.
  localparam logic signed [XW-1:0] XInit  = 24'sd318377;
  localparam logic signed [XW-1:0] Rnd    = 24'sd8;
  localparam logic [31:0]          Deg90  = 32'd5898240;
  localparam logic [31:0]          Deg180 = 32'd11796480;
  localparam logic [31:0]          Deg270 = 32'd17694720;
  localparam logic [31:0]          Deg360 = 32'd23592960;

  typedef enum logic [2:0] {StIdle, StConvert, StReduce, StIterate, StDone} state_e;

  state_e                 state_q, state_d;
  logic [31:0]            angle_q, angle_d, ang_lat_q, ang_lat_d, mag_q, mag_d;
  logic                   neg_q, neg_d, quad_q, quad_d, err_q, err_d;
  logic signed [XW-1:0]   x_q, x_d, y_q, y_d;
  logic signed [ZW-1:0]   z_q, z_d;
  logic [4:0]             iter_q, iter_d;
  logic [15:0]            div_q, div_d, cos_q, cos_d, sin_q, sin_d;
  logic                   awready_q, awready_d, bvalid_q, bvalid_d;
  logic                   arready_q, arready_d, rvalid_q, rvalid_d;
  logic [31:0]            rdata_q, rdata_d;

  logic                   wr_en, rd_en, start, strobe, busy;
  logic [1:0]             waddr, raddr;
  logic [31:0]            status;
  logic [7:0]             exp8;
  logic signed [9:0]      sh;
  logic [9:0]             nsh;
  logic [31:0]            cvt_mag, red_rem, red_r;
  logic signed [ZW-1:0]   red_z, atan_v;
  logic signed [XW-1:0]   x_sh, y_sh;
  logic                   unused_ok;

  function automatic logic signed [ZW-1:0] atan_lut(input logic [3:0] i);
    case (i)
      4'd0:    return 26'sd2949120;
      4'd1:    return 26'sd1740967;
      4'd2:    return 26'sd919879;
      4'd3:    return 26'sd466945;
      4'd4:    return 26'sd234379;
      4'd5:    return 26'sd117304;
      4'd6:    return 26'sd58666;
      4'd7:    return 26'sd29335;
      4'd8:    return 26'sd14668;
      4'd9:    return 26'sd7334;
      4'd10:   return 26'sd3667;
      4'd11:   return 26'sd1833;
      4'd12:   return 26'sd917;
      4'd13:   return 26'sd458;
      4'd14:   return 26'sd229;
      default: return 26'sd115;
    endcase
  endfunction

  // Drop guard bits with rounding, undo the quadrant fold, clamp symmetric.
  function automatic logic [15:0] finish16(input logic signed [XW-1:0] v, input logic neg);
    logic signed [XW-1:0] t;
    t = (v + Rnd) >>> GUARD;
    if (neg) t = -t;
    if (t > 24'sd32767) t = 24'sd32767;
    else if (t < -24'sd32767) t = -24'sd32767;
    return 16'(t);
  endfunction

  assign waddr  = S_AXI_AWADDR[3:2];
  assign raddr  = S_AXI_ARADDR[3:2];
  assign wr_en  = awready_q && S_AXI_AWVALID && S_AXI_WVALID;
  assign rd_en  = arready_q && S_AXI_ARVALID;
  assign busy   = (state_q == StConvert) || (state_q == StReduce) || (state_q == StIterate);
  assign start  = wr_en && (waddr == 2'd0) && S_AXI_WSTRB[0] && S_AXI_WDATA[0] && !busy;
  assign strobe = (div_q == 16'(CLK_DIV - 1));
  assign status = {14'd0, err_q, state_q == StDone, 15'd0, busy};

  // float32 -> unsigned magnitude in 1/65536 degree units
  assign exp8 = ang_lat_q[30:23];
  assign sh   = $signed({2'b00, exp8}) - 10'sd134;
  assign nsh  = 10'(-sh);
  always_comb begin
    cvt_mag = '0;
    if (exp8 == 8'd0)        cvt_mag = '0;
    else if (sh >= 10'sd0)   cvt_mag = {8'd0, 1'b1, ang_lat_q[22:0]} << sh[2:0];
    else if (sh >= -10'sd31) cvt_mag = {8'd0, 1'b1, ang_lat_q[22:0]} >> nsh[4:0];
  end

  assign red_rem = mag_q % Deg360;
  assign red_r   = (neg_q && (red_rem != 32'd0)) ? (Deg360 - red_rem) : red_rem;
  always_comb begin
    if (red_r <= Deg90)      red_z = $signed(ZW'(red_r));
    else if (red_r < Deg270) red_z = $signed(ZW'(red_r)) - $signed(ZW'(Deg180));
    else                     red_z = $signed(ZW'(red_r)) - $signed(ZW'(Deg360));
  end

  assign atan_v = atan_lut(iter_q[3:0]);
  assign x_sh   = x_q >>> iter_q[3:0];
  assign y_sh   = y_q >>> iter_q[3:0];

  always_comb begin
    awready_d = S_AXI_AWVALID && S_AXI_WVALID && !bvalid_q && !awready_q;
    arready_d = S_AXI_ARVALID && !rvalid_q && !arready_q;
    bvalid_d  = wr_en ? 1'b1 : (bvalid_q && !S_AXI_BREADY);
    rvalid_d  = rd_en ? 1'b1 : (rvalid_q && !S_AXI_RREADY);
    rdata_d   = rdata_q;
    angle_d   = angle_q;
    if (rd_en) begin
      case (raddr)
        2'd0:    rdata_d = status;
        2'd1:    rdata_d = angle_q;
        2'd2:    rdata_d = {{16{cos_q[15]}}, cos_q};
        default: rdata_d = {{16{sin_q[15]}}, sin_q};
      endcase
    end
    if (wr_en && (waddr == 2'd1)) begin
      for (int b = 0; b < 4; b++) begin
        if (S_AXI_WSTRB[b]) angle_d[8*b +: 8] = S_AXI_WDATA[8*b +: 8];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ang_lat_d = ang_lat_q;
    mag_d     = mag_q;
    neg_d     = neg_q;
    quad_d    = quad_q;
    err_d     = err_q;
    x_d       = x_q;
    y_d       = y_q;
    z_d       = z_q;
    iter_d    = iter_q;
    cos_d     = cos_q;
    sin_d     = sin_q;
    div_d     = strobe ? 16'd0 : div_q + 16'd1;
    if (start) begin
      state_d   = StConvert;
      err_d     = 1'b0;
      ang_lat_d = angle_q;
      div_d     = 16'd0;
    end else begin
      case (state_q)
        StConvert: begin
          if (exp8 >= 8'd142) begin
            err_d   = 1'b1;
            cos_d   = '0;
            sin_d   = '0;
            state_d = StDone;
          end else begin
            mag_d   = cvt_mag;
            neg_d   = ang_lat_q[31];
            state_d = StReduce;
          end
        end
        StReduce: begin
          z_d     = red_z;
          quad_d  = (red_r > Deg90) && (red_r < Deg270);
          x_d     = XInit;
          y_d     = '0;
          iter_d  = '0;
          state_d = StIterate;
        end
        StIterate: begin
          if (iter_q == 5'd16) begin
            cos_d   = finish16(x_q, quad_q);
            sin_d   = finish16(y_q, quad_q);
            state_d = StDone;
          end else if (strobe) begin
            if (!z_q[ZW-1]) begin
              x_d = x_q - y_sh;
              y_d = y_q + x_sh;
              z_d = z_q - atan_v;
            end else begin
              x_d = x_q + y_sh;
              y_d = y_q - x_sh;
              z_d = z_q + atan_v;
            end
            iter_d = iter_q + 5'd1;
          end
        end
        StIdle, StDone: ;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      state_q   <= StIdle;
      angle_q   <= '0;
      ang_lat_q <= '0;
      mag_q     <= '0;
      neg_q     <= 1'b0;
      quad_q    <= 1'b0;
      err_q     <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      z_q       <= '0;
      iter_q    <= '0;
      div_q     <= '0;
      cos_q     <= '0;
      sin_q     <= '0;
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      angle_q   <= angle_d;
      ang_lat_q <= ang_lat_d;
      mag_q     <= mag_d;
      neg_q     <= neg_d;
      quad_q    <= quad_d;
      err_q     <= err_d;
      x_q       <= x_d;
      y_q       <= y_d;
      z_q       <= z_d;
      iter_q    <= iter_d;
      div_q     <= div_d;
      cos_q     <= cos_d;
      sin_q     <= sin_d;
      awready_q <= awready_d;
      bvalid_q  <= bvalid_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
    end
  end

`ifdef CORDIC_IRQ_EN
  logic irq_q, irq_d;
  always_comb begin
    irq_d = irq_q;
    if (start || (rd_en && (raddr == 2'd0))) irq_d = 1'b0;
    if ((state_q != StDone) && (state_d == StDone)) irq_d = 1'b1;
  end
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) irq_q <= 1'b0;
    else              irq_q <= irq_d;
  end
  assign irq = irq_q;
`endif

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = awready_q;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = 2'b00;
  assign S_AXI_RVALID  = rvalid_q;
  assign unused_ok     = ^{S_AXI_AWADDR, S_AXI_ARADDR};

endmodule

// File: tb/tb_axil_cordic.sv
// Scoreboard bench for axil_cordic: reads push expectations, a monitor checks each R beat.
module tb_axil_cordic;

  localparam int unsigned AW      = 4;
  localparam int unsigned CLK_DIV = 10;
  localparam real         PI      = 3.14159265358979;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] awaddr, araddr;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic [31:0]   wdata, rdata;
  logic [3:0]    wstrb;
  logic [1:0]    bresp, rresp;
  logic          arvalid, arready, rvalid, rready;
`ifdef CORDIC_IRQ_EN
  logic          irq;
`endif

  axil_cordic #(.ADDR_WIDTH(AW), .CLK_DIV(CLK_DIV)) dut (
`ifdef CORDIC_IRQ_EN
    .irq           (irq),
`endif
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESET  (rst),
    .S_AXI_AWADDR  (awaddr),
    .S_AXI_AWVALID (awvalid),
    .S_AXI_AWREADY (awready),
    .S_AXI_WDATA   (wdata),
    .S_AXI_WSTRB   (wstrb),
    .S_AXI_WVALID  (wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_BRESP   (bresp),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),
    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARVALID (arvalid),
    .S_AXI_ARREADY (arready),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready)
  );

  always #5 clk = ~clk;

  // kind 0: exact, 1: signed within tol, 2: status poll (BUSY or final value)
  typedef struct {
    string       name;
    logic [31:0] exp;
    int          tol;
    int          kind;
    bit          in_mse;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;
  real  se_sum  = 0.0;
  int   se_n    = 0;

  always @(negedge clk) begin
    if (!rst && rvalid && rready) begin
      n_tests++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_read: got %h, required no read", rdata);
      end else begin
        bit ok;
        int diff;
        mon_e = sb_q.pop_front();
        diff  = $signed(rdata) - $signed(mon_e.exp);
        case (mon_e.kind)
          0:       ok = (rdata == mon_e.exp);
          1:       ok = (diff <= mon_e.tol) && (diff >= -mon_e.tol);
          default: ok = (rdata == 32'h1) || (rdata == mon_e.exp);
        endcase
        ok = ok && (rresp == 2'b00);
        if (mon_e.in_mse) begin
          se_sum += (real'(diff) / 32768.0) ** 2;
          se_n++;
        end
        if (!ok) begin
          n_fail++;
          $display("FAIL %s: got %h rresp %0d, required %h (tol %0d)",
                   mon_e.name, rdata, rresp, mon_e.exp, mon_e.tol);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int ideal(input real v);
    int r;
    r = $rtoi(v * 32768.0 + ((v >= 0.0) ? 0.5 : -0.5));
    if (r > 32767) r = 32767;
    if (r < -32767) r = -32767;
    return r;
  endfunction

  function automatic logic [31:0] f32_int(input int n);
    logic [31:0] m;
    int          p;
    if (n == 0) return 32'h0;
    m = (n < 0) ? 32'(-n) : 32'(n);
    p = 0;
    for (int i = 0; i < 24; i++) if (m[i]) p = i;
    m = (m << (23 - p)) & 32'h007F_FFFF;
    return {n < 0, 8'(127 + p), m[22:0]};
  endfunction

  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int k;
    @(posedge clk); #1;
    awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1;
    k = 0;
    while (k < 50) begin
      @(negedge clk); k++;
      if (awready && wready) break;
    end
    if (!(awready && wready)) begin
      $display("FAIL write_accept: got awready %0d, required 1", awready);
      $fatal(1, "write timeout");
    end
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    k = 0;
    while (k < 50) begin
      @(negedge clk); k++;
      if (bvalid) break;
    end
    n_tests++;
    if (!bvalid || bresp != 2'b00) begin
      n_fail++;
      $display("FAIL write_resp @%h: got bvalid %0d bresp %0d, required 1/0", addr, bvalid, bresp);
    end
  endtask

  task automatic axi_read(input logic [3:0] addr, output logic [31:0] data);
    int k;
    @(posedge clk); #1;
    araddr = addr; arvalid = 1'b1;
    k = 0;
    while (k < 50) begin
      @(negedge clk); k++;
      if (arready) break;
    end
    if (!arready) begin
      $display("FAIL read_accept: got arready 0, required 1");
      $fatal(1, "read timeout");
    end
    @(posedge clk); #1;
    arvalid = 1'b0;
    k = 0;
    while (k < 50) begin
      @(negedge clk); k++;
      if (rvalid) break;
    end
    if (!rvalid) begin
      $display("FAIL read_valid: got rvalid 0, required 1");
      $fatal(1, "read timeout");
    end
    data = rdata;
  endtask

  task automatic check_read(input string name, input logic [3:0] addr, input logic [31:0] exp,
                            input int tol, input bit in_mse);
    exp_t        e;
    logic [31:0] d;
    e.name = name; e.exp = exp; e.tol = tol; e.kind = (tol > 0) ? 1 : 0; e.in_mse = in_mse;
    sb_q.push_back(e);
    axi_read(addr, d);
  endtask

  task automatic poll_results(input string name, input logic [31:0] exp_status, input int exp_cos,
                              input int exp_sin, input int tol, input bit in_mse);
    exp_t        e;
    logic [31:0] d;
    d = 32'h1;
    for (int i = 0; i < 100 && d == 32'h1; i++) begin
      e.name = {name, "_status"}; e.exp = exp_status; e.tol = 0; e.kind = 2; e.in_mse = 1'b0;
      sb_q.push_back(e);
      axi_read(4'h0, d);
    end
    if (d == 32'h1) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_poll: got status %h after 100 polls, required %h", name, d, exp_status);
    end
    check_read({name, "_cos"}, 4'h8, 32'(exp_cos), tol, in_mse);
    check_read({name, "_sin"}, 4'hC, 32'(exp_sin), tol, in_mse);
  endtask

  task automatic run_angle(input string name, input logic [31:0] bits, input logic [31:0] exp_status,
                           input int exp_cos, input int exp_sin, input int tol, input bit in_mse);
    axi_write(4'h4, bits, 4'hF);
    axi_write(4'h0, 32'h1, 4'hF);
    poll_results(name, exp_status, exp_cos, exp_sin, tol, in_mse);
  endtask

  initial begin
    int k;
    rst = 1'b1;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b1;
    araddr = '0; arvalid = 1'b0; rready = 1'b1;
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;

    check_read("reset_status", 4'h0, 32'h0, 0, 1'b0);
    check_read("reset_angle",  4'h4, 32'h0, 0, 1'b0);
    check_read("reset_cos",    4'h8, 32'h0, 0, 1'b0);
    check_read("reset_sin",    4'hC, 32'h0, 0, 1'b0);

    run_angle("deg0",   32'h0000_0000, 32'h0001_0000,  32767,      0, 4, 1'b0);
    run_angle("deg90",  32'h42B4_0000, 32'h0001_0000,      0,  32767, 4, 1'b0);
    run_angle("deg180", 32'h4334_0000, 32'h0001_0000, -32767,      0, 4, 1'b0);
    run_angle("deg270", 32'h4387_0000, 32'h0001_0000,      0, -32767, 4, 1'b0);
    run_angle("degm90", 32'hC2B4_0000, 32'h0001_0000,      0, -32767, 4, 1'b0);
    run_angle("deg750", 32'h443B_8000, 32'h0001_0000,  28378,  16384, 4, 1'b0);
    run_angle("nan",    32'h7FC0_0000, 32'h0003_0000,      0,      0, 0, 1'b0);
    run_angle("big",    32'h4700_0000, 32'h0003_0000,      0,      0, 0, 1'b0);
    run_angle("deg45",  32'h4234_0000, 32'h0001_0000,  23170,  23170, 4, 1'b0);

    axi_write(4'h4, 32'hAABB_CCDD, 4'b0101);
    check_read("angle_wstrb", 4'h4, 32'h42BB_00DD, 0, 1'b0);

    // Second start lands while busy and must not disturb the 90 degree run.
    axi_write(4'h4, 32'h42B4_0000, 4'hF);
    axi_write(4'h0, 32'h1, 4'hF);
    axi_write(4'h4, 32'h0000_0000, 4'hF);
    axi_write(4'h0, 32'h1, 4'hF);
    poll_results("busy_start", 32'h0001_0000, 0, 32767, 4, 1'b0);
    check_read("angle_after_busy", 4'h4, 32'h0, 0, 1'b0);

    axi_write(4'h4, 32'h4234_0000, 4'hF);
    axi_write(4'h0, 32'h1, 4'hF);
    repeat (40) @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_read("abort_status", 4'h0, 32'h0, 0, 1'b0);
    check_read("abort_angle",  4'h4, 32'h0, 0, 1'b0);
    check_read("abort_cos",    4'h8, 32'h0, 0, 1'b0);
    check_read("abort_sin",    4'hC, 32'h0, 0, 1'b0);

    axi_write(4'h8, 32'h0000_1234, 4'hF);
    axi_write(4'hC, 32'h0000_5678, 4'hF);
    check_read("ro_cos", 4'h8, 32'h0, 0, 1'b0);
    check_read("ro_sin", 4'hC, 32'h0, 0, 1'b0);

    for (int d = 0; d < 360; d += 7) begin
      real r;
      r = real'(d) * PI / 180.0;
      run_angle($sformatf("sweep%0d", d), f32_int(d), 32'h0001_0000,
                ideal($cos(r)), ideal($sin(r)), 4, 1'b1);
    end

    k = 0;
    while (sb_q.size() != 0 && k < 100) begin
      @(negedge clk); k++;
    end
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, required 0", sb_q.size());
    end

    n_tests++;
    if (se_n == 0 || (se_sum / real'(se_n)) >= 1.0e-8) begin
      n_fail++;
      $display("FAIL sweep_mse: got %e over %0d samples, required < 1e-8",
               (se_n == 0) ? 1.0 : se_sum / real'(se_n), se_n);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/axil_cordic.md
Name: axil_cordic

Overview:
- AXI4-Lite slave wrapping an iterative CORDIC sine/cosine engine.
- Software writes an IEEE-754 single-precision angle in degrees, then starts a computation. It polls status and reads back cos and sin as signed Q1.15 values.
- Sits on the processor's AXI4-Lite peripheral bus as a memory-mapped accelerator.

Parameters:
- ADDR_WIDTH, 4, width of AWADDR/ARADDR; only bits [3:2] decode registers.
- CLK_DIV, 10, clock cycles per CORDIC iteration (iteration enable strobe period, ≥1).

Ports:
- S_AXI_ACLK  in  1  single system clock, rising edge.
- S_AXI_ARESET  in  1  synchronous, active-high reset.
- S_AXI_AWADDR  in  ADDR_WIDTH  write address.
- S_AXI_AWVALID  in  1  write address valid.
- S_AXI_AWREADY  out  1  write address accepted.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte enables.
- S_AXI_WVALID  in  1  write data valid.
- S_AXI_WREADY  out  1  write data accepted.
- S_AXI_BRESP  out  2  write response, always 2'b00.
- S_AXI_BVALID  out  1  write response valid.
- S_AXI_BREADY  in  1  master accepts response.
- S_AXI_ARADDR  in  ADDR_WIDTH  read address.
- S_AXI_ARVALID  in  1  read address valid.
- S_AXI_ARREADY  out  1  read address accepted.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  read response, always 2'b00.
- S_AXI_RVALID  out  1  read data valid.
- S_AXI_RREADY  in  1  master accepts data.

Behaviour:
- Register map:
  - 0x0 CTRL/STATUS. Write bit0=1 starts a computation. Read: bit0 BUSY, bit16 DONE, bit17 ERR, other bits 0.
  - 0x4 ANGLE: float32 degrees, R/W, WSTRB byte-masked.
  - 0x8 COS: read-only, sign-extended Q1.15.
  - 0xC SIN: read-only, sign-extended Q1.15.
  - Writes to 0x8/0xC are ignored but still answered with OKAY.
- Reset: all READY/VALID low, RDATA 0, all registers 0, status 0, FSM IDLE.
- Write channel:
  - AWREADY and WREADY pulse high together for 1 cycle when AWVALID && WVALID && !BVALID.
  - Register updates on that edge.
  - BVALID rises the next cycle and holds until BREADY is sampled high.
- Read channel:
  - ARREADY pulses 1 cycle when ARVALID && !RVALID.
  - RVALID and RDATA are registered the next cycle; RVALID holds until RREADY.
  - RDATA keeps its last value until the next read completes.
- Start:
  - Accepted only in IDLE or DONE; ignored while BUSY.
  - Clears DONE and ERR, sets BUSY, and latches ANGLE.
- FSM states:
  - IDLE → CONVERT (1 cycle): float32 to signed fixed-point degrees. NaN, Inf, or |angle| ≥ 32768° sets ERR, COS=SIN=0, and goes to DONE.
  - CONVERT → REDUCE: modulo 360 into [0,360). Fold into [-90,90] with a quadrant flag that negates cos/sin after iteration.
  - REDUCE → ITERATE: 16 rotation-mode iterations.
    - One iteration per enable strobe; the strobe fires every CLK_DIV cycles from a free counter restarted at start.
    - x0 = K·2^15 (≈19898), y0 = 0.
    - Internal width ≥18 bits plus guard bits; atan table in the same angle units.
  - ITERATE → DONE: apply quadrant correction and saturate to [-32767, 32767]. Write COS/SIN, clear BUSY, set DONE.
- Status reads exactly 0x00010000 after a successful computation.
- Accuracy: |error| ≤ 4 LSB versus ideal for all integer degrees 0..359.
- Latency from the start write: ≤ 4 + 16·CLK_DIV cycles.
- Simultaneous AXI read of STATUS on the completion edge returns the pre-update value.
- Reset mid-computation aborts it and returns everything to reset values.

Optional Feature:
- Macro CORDIC_IRQ_EN.
- When defined: adds output irq (1 bit), registered. irq goes high on entry to DONE and clears on a STATUS read or a new start.
- When undefined: no irq port; behaviour otherwise identical.

Test Plan:
- Reset, then read 0x0, 0x8, 0xC → all 0x00000000, RRESP 00.
- Write 0x4=0x00000000 (0.0°), write 0x0=1, poll → status 0x00010000; COS low16 ≈0x7FFF (±4); SIN ≈0x0000 (±4).
- Angle 0x42B40000 (90.0°) → SIN ≈0x7FFF; COS ≈0 (±4).
- Angle 0x43340000 (180.0°) → COS ≈0x8001 (−32767 ±4); SIN ≈0. Angle 0x43870000 (270.0°) → SIN ≈0x8001.
- Angle 0x7FC00000 (NaN) → status 0x00030000; COS=SIN=0.
- Sweep 0..359° (float32) with CLK_DIV=10 → mean squared error per output < 1e-8. A start written while BUSY is ignored: the result matches the first angle.
